// File: rtl/segdisp_ctrl.sv
// Signed-decimal 7-segment controller: shift-add-3 BCD conversion, atomic commit, digit multiplexing.
// Optional hex display path enabled by defining SEGDISP_HEX_EN (adds hex_mode input).
module segdisp_ctrl #(
  parameter int DATA_W    = 11,
  parameter int DIGITS    = 4,
  parameter int REFRESH_W = 18
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel,
`ifdef SEGDISP_HEX_EN
  input  logic              hex_mode,
`endif
  input  logic [DATA_W-1:0] data_in,
  output logic              busy,
  output logic              ovf,
  output logic [DIGITS-1:0] an,
  output logic [7:0]        seg
);

  localparam int NUM_D = DIGITS - 1;
  localparam int BCD_W = 4 * NUM_D;
  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SEG_DASH  = 8'hFD;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    case (v)
      4'h0: seg_of = 8'h03;
      4'h1: seg_of = 8'h9F;
      4'h2: seg_of = 8'h25;
      4'h3: seg_of = 8'h0D;
      4'h4: seg_of = 8'h99;
      4'h5: seg_of = 8'h49;
      4'h6: seg_of = 8'h41;
      4'h7: seg_of = 8'h1F;
      4'h8: seg_of = 8'h01;
      4'h9: seg_of = 8'h09;
      4'hA: seg_of = 8'h11;
      4'hB: seg_of = 8'hC1;
      4'hC: seg_of = 8'h63;
      4'hD: seg_of = 8'h85;
      4'hE: seg_of = 8'h61;
      default: seg_of = 8'h71;
    endcase
  endfunction

  state_t                  state_q, state_d;
  logic                    busy_q, busy_d;
  logic                    ovf_q, ovf_d;
  logic                    sign_q, sign_d;
  logic [DATA_W-1:0]       mag_q, mag_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic                    bovf_q, bovf_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [DIGITS-1:0][7:0]  digit_q, digit_d;
  logic [REFRESH_W-1:0]    presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0]       an_q, an_d;
  logic [7:0]              seg_q, seg_d;

  logic [BCD_W-1:0]        adj;
  logic                    lead;
  logic [3:0]              nib;
  int unsigned             di;

`ifdef SEGDISP_HEX_EN
  localparam int HEX_W = 4 * DIGITS;
  localparam int EXT_W = (DATA_W > HEX_W) ? DATA_W : HEX_W;
  logic [HEX_W-1:0] hex_q, hex_d;
  logic             hexm_q, hexm_d;
  logic [EXT_W-1:0] ext;
`endif

  always_comb begin
    state_d = state_q;
    busy_d  = busy_q;
    ovf_d   = ovf_q;
    sign_d  = sign_q;
    mag_d   = mag_q;
    bcd_d   = bcd_q;
    bovf_d  = bovf_q;
    cnt_d   = cnt_q;
    digit_d = digit_q;
    adj     = bcd_q;
    lead    = 1'b1;
    nib     = '0;
    di      = 0;
`ifdef SEGDISP_HEX_EN
    hex_d   = hex_q;
    hexm_d  = hexm_q;
    ext     = EXT_W'(data_in);
`endif

    case (state_q)
      IDLE: begin
        if (sel) begin
          sign_d  = data_in[DATA_W-1];
          mag_d   = data_in[DATA_W-1] ? (~data_in + DATA_W'(1)) : data_in;
          bcd_d   = '0;
          bovf_d  = 1'b0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CONV;
`ifdef SEGDISP_HEX_EN
          hexm_d = hex_mode;
          hex_d  = ext[HEX_W-1:0];
          if (hex_mode) state_d = COMMIT;
`endif
        end
      end

      CONV: begin
        for (int unsigned k = 0; k < NUM_D; k++) begin
          if (adj[4*k +: 4] >= 4'd5) adj[4*k +: 4] = adj[4*k +: 4] + 4'd3;
        end
        // Top bit of the adjusted accumulator is what falls off on the shift.
        bovf_d = bovf_q | adj[BCD_W-1];
        bcd_d  = {adj[BCD_W-2:0], mag_q[DATA_W-1]};
        mag_d  = {mag_q[DATA_W-2:0], 1'b0};
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(DATA_W - 1)) state_d = COMMIT;
      end

      COMMIT: begin
        busy_d  = 1'b0;
        state_d = IDLE;
        ovf_d   = bovf_q;
        if (bovf_q) begin
          for (int unsigned k = 0; k < DIGITS; k++) digit_d[k] = SEG_DASH;
        end else begin
          // Walk numeric digits MSB-first; digit 0 is never blanked.
          for (int unsigned k = 0; k < NUM_D; k++) begin
            di  = NUM_D - 1 - k;
            nib = bcd_q[4*di +: 4];
            if (lead && nib == 4'd0 && di != 0) begin
              digit_d[di] = SEG_BLANK;
            end else begin
              lead        = 1'b0;
              digit_d[di] = seg_of(nib);
            end
          end
          digit_d[DIGITS-1] = sign_q ? SEG_DASH : SEG_BLANK;
        end
`ifdef SEGDISP_HEX_EN
        if (hexm_q) begin
          ovf_d = 1'b0;
          for (int unsigned k = 0; k < DIGITS; k++) digit_d[k] = seg_of(hex_q[4*k +: 4]);
        end
`endif
      end

      default: state_d = IDLE;
    endcase

    presc_d = presc_q + REFRESH_W'(1);
    idx_d   = idx_q;
    if (presc_q == '1) idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
    an_d  = ~(DIGITS'(1) << idx_q);
    seg_d = digit_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      ovf_q   <= 1'b0;
      sign_q  <= 1'b0;
      mag_q   <= '0;
      bcd_q   <= '0;
      bovf_q  <= 1'b0;
      cnt_q   <= '0;
      digit_q <= '1;
      presc_q <= '0;
      idx_q   <= '0;
      an_q    <= ~DIGITS'(1);
      seg_q   <= '1;
`ifdef SEGDISP_HEX_EN
      hex_q   <= '0;
      hexm_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      ovf_q   <= ovf_d;
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      bcd_q   <= bcd_d;
      bovf_q  <= bovf_d;
      cnt_q   <= cnt_d;
      digit_q <= digit_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
`ifdef SEGDISP_HEX_EN
      hex_q   <= hex_d;
      hexm_q  <= hexm_d;
`endif
    end
  end

  assign busy = busy_q;
  assign ovf  = ovf_q;
  assign an   = an_q;
  assign seg  = seg_q;

endmodule

// File: tb/tb_segdisp_ctrl.sv
// Directed self-checking bench for segdisp_ctrl (DATA_W=11, DIGITS=4, REFRESH_W=2).
module tb_segdisp_ctrl;
  localparam int DATA_W    = 11;
  localparam int DIGITS    = 4;
  localparam int REFRESH_W = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              sel;
  logic [DATA_W-1:0] data_in;
  logic              busy;
  logic              ovf;
  logic [DIGITS-1:0] an;
  logic [7:0]        seg;
`ifdef SEGDISP_HEX_EN
  logic              hex_mode;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0] cap [DIGITS];
  logic [3:0] seq [$];
  logic [3:0] last_an;

  always #5 clk = ~clk;

  segdisp_ctrl #(
    .DATA_W(DATA_W),
    .DIGITS(DIGITS),
    .REFRESH_W(REFRESH_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sel(sel),
`ifdef SEGDISP_HEX_EN
    .hex_mode(hex_mode),
`endif
    .data_in(data_in),
    .busy(busy),
    .ovf(ovf),
    .an(an),
    .seg(seg)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic capture();
    for (int i = 0; i < DIGITS; i++) cap[i] = 'x;
    repeat (20) begin
      @(negedge clk);
      for (int i = 0; i < DIGITS; i++)
        if (an === ~(4'b0001 << i)) cap[i] = seg;
    end
  endtask

  task automatic check_disp(input string tag, input logic [31:0] exp);
    @(posedge clk);
    capture();
    for (int i = 0; i < DIGITS; i++) chk($sformatf("%s_d%0d", tag, i), {24'h0, cap[i]}, {24'h0, exp[8*i +: 8]});
  endtask

  task automatic load(input logic [DATA_W-1:0] v);
    @(negedge clk);
    sel     = 1'b1;
    data_in = v;
`ifdef SEGDISP_HEX_EN
    hex_mode = 1'b0;
`endif
    @(posedge clk);
    #1;
    sel = 1'b0;
  endtask

  // Counts busy-high cycles; optionally checks the old display holds and injects a sel pulse.
  task automatic wait_idle(input string tag, input int exp_n, input logic hold,
                           input logic [31:0] old, input int inj, input logic [DATA_W-1:0] inj_v);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      @(negedge clk);
      if (hold)
        for (int i = 0; i < DIGITS; i++)
          if (an === ~(4'b0001 << i)) chk({tag, "_hold"}, {24'h0, seg}, {24'h0, old[8*i +: 8]});
      if (n == inj) begin
        sel     = 1'b1;
        data_in = inj_v;
      end else begin
        sel = 1'b0;
      end
      @(posedge clk);
      #1;
      n++;
    end
    sel = 1'b0;
    chk({tag, "_busy_cycles"}, n, exp_n);
  endtask

  initial begin
    rst     = 1'b1;
    sel     = 1'b0;
    data_in = '0;
`ifdef SEGDISP_HEX_EN
    hex_mode = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_ovf", {31'h0, ovf}, 32'h0);
    chk("rst_an", {28'h0, an}, 32'hE);
    chk("rst_seg", {24'h0, seg}, 32'hFF);
    rst = 1'b0;

    last_an = an;
    seq.push_back(an);
    repeat (20) begin
      @(negedge clk);
      if (an !== last_an) begin
        seq.push_back(an);
        last_an = an;
      end
    end
    chk("scan_len_ok", {31'h0, seq.size() >= 4}, 32'h1);
    chk("scan_an0", {28'h0, seq[0]}, 32'hE);
    chk("scan_an1", {28'h0, seq[1]}, 32'hD);
    chk("scan_an2", {28'h0, seq[2]}, 32'hB);
    chk("scan_an3", {28'h0, seq[3]}, 32'h7);
    check_disp("rst", 32'hFFFFFFFF);

    load(11'd123);
    chk("pos_busy_rise", {31'h0, busy}, 32'h1);
    wait_idle("pos", 12, 1'b0, 32'h0, -1, '0);
    chk("pos_ovf", {31'h0, ovf}, 32'h0);
    check_disp("pos", 32'hFF9F250D);

    load(11'h7F9);
    wait_idle("neg", 12, 1'b0, 32'h0, -1, '0);
    chk("neg_ovf", {31'h0, ovf}, 32'h0);
    check_disp("neg", 32'hFDFFFF1F);

    load(11'h400);
    wait_idle("ovf", 12, 1'b0, 32'h0, -1, '0);
    chk("ovf_flag", {31'h0, ovf}, 32'h1);
    check_disp("ovf", 32'hFDFDFDFD);

    load(11'd0);
    wait_idle("zero", 12, 1'b0, 32'h0, -1, '0);
    chk("zero_ovf", {31'h0, ovf}, 32'h0);
    check_disp("zero", 32'hFFFFFF03);

    load(11'd789);
    wait_idle("ign", 12, 1'b1, 32'hFFFFFF03, 2, 11'd456);
    repeat (3) @(posedge clk);
    #1;
    chk("ign_not_queued", {31'h0, busy}, 32'h0);
    check_disp("ign", 32'hFF1F0109);

    load(11'h400);
    wait_idle("ovf2", 12, 1'b0, 32'h0, -1, '0);
    chk("ovf2_flag", {31'h0, ovf}, 32'h1);

    load(11'd123);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mrst_busy", {31'h0, busy}, 32'h0);
    chk("mrst_ovf", {31'h0, ovf}, 32'h0);
    repeat (15) @(posedge clk);
    #1;
    chk("mrst_no_commit", {31'h0, busy}, 32'h0);
    check_disp("mrst", 32'hFFFFFFFF);

`ifdef SEGDISP_HEX_EN
    @(negedge clk);
    sel      = 1'b1;
    hex_mode = 1'b1;
    data_in  = 11'h2AF;
    @(posedge clk);
    #1;
    sel      = 1'b0;
    hex_mode = 1'b0;
    wait_idle("hex", 1, 1'b0, 32'h0, -1, '0);
    chk("hex_ovf", {31'h0, ovf}, 32'h0);
    check_disp("hex", 32'h03251171);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
